// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback. Stalls on mem_ready.
// Flags undecodable instructions and counts retired instructions.
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [5:0]       alu_funct,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SUB   = 6'b100010;

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             r_funct_ok;

    // The branch comparison itself happens in the datapath (pc_write_cond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    assign r_funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b100110, 6'b101010};

    // Next-state, illegal-instruction and retire decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (r_funct_ok) state_d = S_R_EXEC;
                        else            illegal_d = 1'b1;
                    end
                    OP_LW, OP_SW:                            state_d = S_MEM_ADDR;
                    OP_BEQ:                                  state_d = S_BEQ;
                    OP_J:                                    state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
                    default:                                 illegal_d = 1'b1;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   retire  = 1'b1;
            S_MEM_WR: begin
                state_d = mem_ready ? S_FETCH : S_MEM_WR;
                retire  = mem_ready;
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     retire  = 1'b1;
            S_BEQ:      retire  = 1'b1;
            S_JUMP:     retire  = 1'b1;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     retire  = 1'b1;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore datapath controls; FETCH additionally gates IR/PC loads on mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        alu_funct     = 6'b000000;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                alu_funct = funct;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b10;
                alu_funct     = FN_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_funct = op_q;
                case (op_q)
                    OP_ADDI: alu_op = 2'b00;
                    OP_SLTI: alu_op = 2'b01;
                    default: alu_op = 2'b11;
                endcase
            end
            S_I_WB:     reg_write = 1'b1;
            default: ;
        endcase
    end

    // State, latched opcode, illegal pulse and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign instr_retired = cnt_q;

endmodule
